otter_cu_fsm: RTL and testbench

Multi-cycle control-unit state machine for the OTTER RV32I core. It sequences fetch, execute, writeback and interrupt entry, and drives the write and read enables that bracket each ALU operation. It sits beside the combinational decoder, which selects ALU ops and muxes. It also keeps a retired-instruction counter.

---
 rtl/otter_cu_fsm_if.sv | 34 +++
 rtl/otter_cu_fsm.sv | 123 ++++++++++++
 tb/tb_otter_cu_fsm.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_cu_fsm_if.sv
// Control-unit bundle: decoder fields and interrupt in, datapath enables out.
// The FSM side uses the slave modport.
interface otter_cu_fsm_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic             intr;
    logic             PC_WE;
    logic             RF_WE;
    logic             memWE2;
    logic             memRDEN1;
    logic             memRDEN2;
    logic             reset;
    logic             csr_WE;
    logic             int_taken;
    logic             mret_exec;
    logic [2:0]       fsm_state;
    logic [CNT_W-1:0] instret;

    modport master (
        output opcode, func3, intr,
        input  PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2,
        input  reset, csr_WE, int_taken, mret_exec,
        input  fsm_state, instret
    );

    modport slave (
        input  opcode, func3, intr,
        output PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2,
        output reset, csr_WE, int_taken, mret_exec,
        output fsm_state, instret
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle control FSM: fetch/exec/writeback/interrupt sequencing
// with Mealy enables and a retired-instruction counter.
module otter_cu_fsm #(
    parameter int CNT_W = 32
) (
    input logic           CLK,
    input logic           RST,
    otter_cu_fsm_if.slave cu
);
    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    state_t           state;
    state_t           next;
    logic             retire;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) state <= INIT;
        else     state <= next;
    end

    always_comb begin
        next = INIT;
        case (state)
            INIT:  next = FETCH;
            FETCH: next = EXEC;
            EXEC: begin
                if (cu.opcode == OP_LOAD) next = WB;
                else if (cu.intr)         next = INTR;
                else                      next = FETCH;
            end
            WB:      next = cu.intr ? INTR : FETCH;
            INTR:    next = FETCH;
            default: next = INIT;
        endcase
    end

    // An instruction retires on the edge that leaves its last cycle
    assign retire = !RST &&
                    ((state == EXEC && cu.opcode != OP_LOAD) ||
                     state == WB);

    always_ff @(posedge CLK) begin
        if (RST)         cnt <= '0;
        else if (retire) cnt <= cnt + CNT_W'(1);
    end

    always_comb begin
        cu.PC_WE     = 1'b0;
        cu.RF_WE     = 1'b0;
        cu.memWE2    = 1'b0;
        cu.memRDEN1  = 1'b0;
        cu.memRDEN2  = 1'b0;
        cu.reset     = 1'b0;
        cu.csr_WE    = 1'b0;
        cu.int_taken = 1'b0;
        cu.mret_exec = 1'b0;
        if (RST) begin
            cu.reset = 1'b1;
        end else begin
            case (state)
                INIT:  cu.reset    = 1'b1;
                FETCH: cu.memRDEN1 = 1'b1;
                EXEC: begin
                    case (cu.opcode)
                        OP_LOAD: cu.memRDEN2 = 1'b1;
                        OP_STORE: begin
                            cu.memWE2 = 1'b1;
                            cu.PC_WE  = 1'b1;
                        end
                        OP_OP, OP_IMM, OP_LUI,
                        OP_AUIPC, OP_JAL, OP_JALR: begin
                            cu.RF_WE = 1'b1;
                            cu.PC_WE = 1'b1;
                        end
                        OP_SYS: begin
                            cu.PC_WE = 1'b1;
                            case (cu.func3)
                                3'b000: cu.mret_exec = 1'b1;
                                3'b001, 3'b010, 3'b011: begin
                                    cu.RF_WE  = 1'b1;
                                    cu.csr_WE = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        // Branches and illegal opcodes only advance PC
                        default: cu.PC_WE = 1'b1;
                    endcase
                end
                WB: begin
                    cu.RF_WE = 1'b1;
                    cu.PC_WE = 1'b1;
                end
                INTR: begin
                    cu.int_taken = 1'b1;
                    cu.PC_WE     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cu.fsm_state = state;
    assign cu.instret   = cnt;
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Randomised instruction-level bench for otter_cu_fsm against a
// per-instruction cycle/enable model.
module tb_otter_cu_fsm;
    localparam int CNT_W = 4;

    localparam logic [8:0] E_PC   = 9'h100;
    localparam logic [8:0] E_RF   = 9'h080;
    localparam logic [8:0] E_MW   = 9'h040;
    localparam logic [8:0] E_MR1  = 9'h020;
    localparam logic [8:0] E_MR2  = 9'h010;
    localparam logic [8:0] E_RST  = 9'h008;
    localparam logic [8:0] E_CSR  = 9'h004;
    localparam logic [8:0] E_INT  = 9'h002;
    localparam logic [8:0] E_MRET = 9'h001;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   pass_cnt = 0;
    int   total = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    otter_cu_fsm_if #(.CNT_W(CNT_W)) bus ();

    otter_cu_fsm #(.CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .cu  (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [8:0] outs();
        return {bus.PC_WE, bus.RF_WE, bus.memWE2, bus.memRDEN1,
                bus.memRDEN2, bus.reset, bus.csr_WE, bus.int_taken,
                bus.mret_exec};
    endfunction

    // Expected EXEC-cycle enables straight from the opcode table
    function automatic logic [8:0] exec_exp(logic [6:0] op, logic [2:0] f3);
        case (op)
            7'b0000011: return E_MR2;
            7'b0100011: return E_MW | E_PC;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return E_RF | E_PC;
            7'b1110011: begin
                if (f3 == 3'b000) return E_MRET | E_PC;
                if (f3 >= 3'b001 && f3 <= 3'b011) return E_RF | E_CSR | E_PC;
                return E_PC;
            end
            default: return E_PC;
        endcase
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction starting in its FETCH cycle; ends in next FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic irq, input string tag);
        bit is_load;
        is_load = (op == 7'b0000011);
        bus.opcode = op;
        bus.func3 = f3;
        bus.intr = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (bus.fsm_state !== 3'd1)
            $display("FAIL %s fetch_state: got %0d want 1", tag, bus.fsm_state);
        else pass_cnt++;
        total++;
        if (outs() !== E_MR1)
            $display("FAIL %s fetch_en: got %h want %h", tag, outs(), E_MR1);
        else pass_cnt++;
        tick();
        bus.intr = is_load ? 1'($urandom_range(0, 1)) : irq;
        #1;
        total++;
        if (bus.fsm_state !== 3'd2 || outs() !== exec_exp(op, f3))
            $display("FAIL %s exec: got st=%0d en=%h want st=2 en=%h",
                     tag, bus.fsm_state, outs(), exec_exp(op, f3));
        else pass_cnt++;
        tick();
        if (is_load) begin
            bus.intr = irq;
            #1;
            total++;
            if (bus.fsm_state !== 3'd3 || outs() !== (E_RF | E_PC) ||
                bus.instret !== exp_cnt)
                $display("FAIL %s wb: got st=%0d en=%h cnt=%0d want st=3 en=%h cnt=%0d",
                         tag, bus.fsm_state, outs(), bus.instret,
                         E_RF | E_PC, exp_cnt);
            else pass_cnt++;
            tick();
        end
        exp_cnt = exp_cnt + 1'b1;
        if (irq) begin
            bus.intr = 1'b1;
            #1;
            total++;
            if (bus.fsm_state !== 3'd4 || outs() !== (E_INT | E_PC))
                $display("FAIL %s intr: got st=%0d en=%h want st=4 en=%h",
                         tag, bus.fsm_state, outs(), E_INT | E_PC);
            else pass_cnt++;
            tick();
        end
        bus.intr = 1'b0;
        total++;
        if (bus.fsm_state !== 3'd1 || bus.instret !== exp_cnt)
            $display("FAIL %s retire: got st=%0d cnt=%0d want st=1 cnt=%0d",
                     tag, bus.fsm_state, bus.instret, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.opcode = 7'b0100011;
        bus.func3 = 3'b000;
        bus.intr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.fsm_state !== 3'd0 || outs() !== E_RST || bus.instret !== 0)
                $display("FAIL reset_hold: got st=%0d en=%h cnt=%0d want st=0 en=%h cnt=0",
                         bus.fsm_state, outs(), bus.instret, E_RST);
            else pass_cnt++;
        end
        RST = 1'b0;
        bus.intr = 1'b0;
        #1;
        total++;
        if (outs() !== E_RST)
            $display("FAIL reset_init: got en=%h want %h", outs(), E_RST);
        else pass_cnt++;
        tick();
        exp_cnt = '0;
        total++;
        if (bus.fsm_state !== 3'd1 || bus.instret !== 0)
            $display("FAIL reset_release: got st=%0d cnt=%0d want st=1 cnt=0",
                     bus.fsm_state, bus.instret);
        else pass_cnt++;
    endtask

    task automatic test_add();
        run_instr(7'b0110011, 3'b000, 1'b0, "add");
    endtask

    task automatic test_load();
        run_instr(7'b0000011, 3'b010, 1'b0, "load");
        run_instr(7'b0000011, 3'b000, 1'b1, "load_irq");
    endtask

    task automatic test_intr();
        run_instr(7'b0100011, 3'b010, 1'b1, "store_irq");
    endtask

    task automatic test_system();
        run_instr(7'b1110011, 3'b001, 1'b0, "csrrw");
        run_instr(7'b1110011, 3'b000, 1'b1, "mret_irq");
        run_instr(7'b1110011, 3'b100, 1'b0, "sys_other");
        run_instr(7'b1111111, 3'b000, 1'b0, "illegal");
        run_instr(7'b1100011, 3'b001, 1'b0, "branch");
    endtask

    task automatic test_random();
        logic [6:0] ops [12];
        logic [6:0] op;
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011,
                7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b1100111, 7'b1110011, 7'b1110011, 7'b0000000};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            run_instr(op, 3'($urandom), 1'($urandom_range(0, 1)), "rand");
        end
    endtask

    task automatic test_rst_mid();
        bus.opcode = 7'b0100011;
        bus.func3 = 3'b010;
        tick();
        total++;
        if (bus.fsm_state !== 3'd2 || bus.memWE2 !== 1'b1)
            $display("FAIL rst_mid_pre: got st=%0d we=%b want st=2 we=1",
                     bus.fsm_state, bus.memWE2);
        else pass_cnt++;
        RST = 1'b1;
        bus.intr = 1'b1;
        #1;
        total++;
        if (outs() !== E_RST)
            $display("FAIL rst_mid_en: got %h want %h", outs(), E_RST);
        else pass_cnt++;
        tick();
        exp_cnt = '0;
        total++;
        if (bus.fsm_state !== 3'd0 || bus.instret !== 0)
            $display("FAIL rst_mid_state: got st=%0d cnt=%0d want st=0 cnt=0",
                     bus.fsm_state, bus.instret);
        else pass_cnt++;
        RST = 1'b0;
        bus.intr = 1'b0;
        tick();
        total++;
        if (bus.fsm_state !== 3'd1)
            $display("FAIL rst_mid_fetch: got st=%0d want 1", bus.fsm_state);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        while (exp_cnt != '1)
            run_instr(7'b0010011, 3'b000, 1'b0, "wrap_fill");
        total++;
        if (bus.instret !== {CNT_W{1'b1}})
            $display("FAIL wrap_full: got %0d want %0d", bus.instret, exp_cnt);
        else pass_cnt++;
        run_instr(7'b0110011, 3'b000, 1'b0, "wrap");
        total++;
        if (bus.instret !== 0)
            $display("FAIL wrap_zero: got %0d want 0", bus.instret);
        else pass_cnt++;
    endtask

    initial begin
        bus.opcode = 7'b0;
        bus.func3 = 3'b0;
        bus.intr = 1'b0;
        test_reset();
        test_add();
        test_load();
        test_intr();
        test_system();
        test_random();
        test_rst_mid();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
